// File: rtl/trap_sequencer_if.sv
// Handshake bundle between the execute-stage trap decoder, the trap sequencer
// and the trap handler. master drives decoder flags and the ack; slave is the sequencer.
interface trap_sequencer_if #(
    parameter int VEC_W = 8
);
    logic             valid;
    logic             stall_in;
    logic             tagtrap;
    logic             pov_unflow;
    logic             gstrap;
    logic             trapinstr;
    logic             skip_cond_enable;
    logic             cond_true;
    logic [2:0]       trap_num;
    logic             handler_ack;
    logic             squash;
    logic             pipe_hold;
    logic             trap_req;
    logic [2:0]       trap_cause;
    logic [VEC_W-1:0] trap_vector;
    logic             skip_next;
    logic             trap_err;
    logic [7:0]       trap_count;

    modport master (
        output valid, stall_in, tagtrap, pov_unflow, gstrap, trapinstr,
               skip_cond_enable, cond_true, trap_num, handler_ack,
        input  squash, pipe_hold, trap_req, trap_cause, trap_vector,
               skip_next, trap_err, trap_count
    );

    modport slave (
        input  valid, stall_in, tagtrap, pov_unflow, gstrap, trapinstr,
               skip_cond_enable, cond_true, trap_num, handler_ack,
        output squash, pipe_hold, trap_req, trap_cause, trap_vector,
               skip_next, trap_err, trap_count
    );
endinterface

// File: rtl/trap_sequencer.sv
// Prioritises execute-stage trap flags, squashes and holds the pipe, requests the
// trap handler and waits for its ack; conditional skips become a one-cycle kill.
module trap_sequencer #(
    parameter int               VEC_W        = 8,
    parameter logic [VEC_W-1:0] VEC_BASE     = 'h80,
    parameter int               DRAIN_CYCLES = 2,
    parameter int               TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SQUASH, REQ, DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [7:0]       tmo_cnt_reg, tmo_cnt_next;
    logic [3:0]       drain_cnt_reg, drain_cnt_next;
    logic             squash_reg, squash_next;
    logic             pipe_hold_reg, pipe_hold_next;
    logic             trap_req_reg, trap_req_next;
    logic             skip_reg, skip_next;
    logic             trap_err_reg, trap_err_next;
    logic [2:0]       cause_reg, cause_next;
    logic [VEC_W-1:0] vector_reg, vector_next;
    logic [7:0]       count_reg, count_next;

    logic             sample;
    logic             trap_take;
    logic             timeout_hit;
    logic [2:0]       cause_c;
    logic [2:0]       num_sel;
    logic [5:0]       off6;
    logic [VEC_W-1:0] offset;
    logic [VEC_W-1:0] vector_c;

    assign sample = (state_reg == IDLE) && bus.valid && !bus.stall_in;

    always_comb begin
        cause_c = 3'd0;
        if (bus.tagtrap)         cause_c = 3'd1;
        else if (bus.pov_unflow) cause_c = 3'd2;
        else if (bus.gstrap)     cause_c = 3'd3;
        else if (bus.trapinstr)  cause_c = 3'd4;
    end

    assign trap_take   = sample && (cause_c != 3'd0);
    assign timeout_hit = (tmo_cnt_reg == TMO_LAST);

    // Only the trap instruction contributes its trap-number field to the vector.
    assign num_sel = (cause_c == 3'd4) ? bus.trap_num : 3'd0;
    assign off6    = {cause_c, num_sel};

    // Zero-extend (or truncate) the 6-bit offset to the vector width.
    for (genvar gi = 0; gi < VEC_W; gi++) begin : g_offset
        if (gi < 6) begin : g_bit
            assign offset[gi] = off6[gi];
        end else begin : g_zero
            assign offset[gi] = 1'b0;
        end
    end

    assign vector_c = VEC_BASE + offset;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trap_take) state_next = SQUASH;
            SQUASH:  state_next = REQ;
            REQ:     if (bus.handler_ack || timeout_hit) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg <= 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that they come out registered.
    always_comb begin
        squash_next    = (state_next == SQUASH);
        pipe_hold_next = (state_next != IDLE);
        trap_req_next  = (state_next == REQ);
        skip_next      = sample && (cause_c == 3'd0) && bus.skip_cond_enable && bus.cond_true;
        trap_err_next  = trap_err_reg ||
                         ((state_reg == REQ) && !bus.handler_ack && timeout_hit);
        cause_next     = cause_reg;
        vector_next    = vector_reg;
        count_next     = count_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        if (trap_take) begin
            cause_next  = cause_c;
            vector_next = vector_c;
            if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
        end
        case (state_reg)
            SQUASH: tmo_cnt_next = 8'd0;
            REQ: begin
                tmo_cnt_next = tmo_cnt_reg + 8'd1;
                if (bus.handler_ack || timeout_hit) drain_cnt_next = DRAIN_LOAD;
            end
            DRAIN:   drain_cnt_next = drain_cnt_reg - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_reg   <= 8'd0;
            drain_cnt_reg <= 4'd0;
            squash_reg    <= 1'b0;
            pipe_hold_reg <= 1'b0;
            trap_req_reg  <= 1'b0;
            skip_reg      <= 1'b0;
            trap_err_reg  <= 1'b0;
            cause_reg     <= 3'd0;
            vector_reg    <= '0;
            count_reg     <= 8'd0;
        end else begin
            tmo_cnt_reg   <= tmo_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            squash_reg    <= squash_next;
            pipe_hold_reg <= pipe_hold_next;
            trap_req_reg  <= trap_req_next;
            skip_reg      <= skip_next;
            trap_err_reg  <= trap_err_next;
            cause_reg     <= cause_next;
            vector_reg    <= vector_next;
            count_reg     <= count_next;
        end
    end

    assign bus.squash      = squash_reg;
    assign bus.pipe_hold   = pipe_hold_reg;
    assign bus.trap_req    = trap_req_reg;
    assign bus.skip_next   = skip_reg;
    assign bus.trap_err    = trap_err_reg;
    assign bus.trap_cause  = cause_reg;
    assign bus.trap_vector = vector_reg;
    assign bus.trap_count  = count_reg;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: hand-computed causes, vectors and cycle timing.
module tb_trap_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_count;

    trap_sequencer_if #(.VEC_W(8)) bus ();

    trap_sequencer #(
        .VEC_W(8), .VEC_BASE(8'h80), .DRAIN_CYCLES(2), .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.valid            = 1'b0;
        bus.stall_in         = 1'b0;
        bus.tagtrap          = 1'b0;
        bus.pov_unflow       = 1'b0;
        bus.gstrap           = 1'b0;
        bus.trapinstr        = 1'b0;
        bus.skip_cond_enable = 1'b0;
        bus.cond_true        = 1'b0;
        bus.trap_num         = 3'd0;
        bus.handler_ack      = 1'b0;
    endtask

    task automatic bump_count();
        if (exp_count < 255) exp_count++;
    endtask

    // Waits (bounded) for trap_req, acks, then waits (bounded) for the pipe to release.
    task automatic finish_trap(input string tag);
        int n;
        n = 0;
        while (!bus.trap_req && n < 10) begin step(); n++; end
        chk({tag, "_req_seen"}, 32'(bus.trap_req), 32'd1);
        bus.handler_ack = 1'b1;
        step();
        bus.handler_ack = 1'b0;
        n = 0;
        while (bus.pipe_hold && n < 10) begin step(); n++; end
        chk({tag, "_released"}, 32'(bus.pipe_hold), 32'd0);
    endtask

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        exp_count = 0;
        clear_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        $display("txn reset");
        chk("rst_squash", 32'(bus.squash), 32'd0);
        chk("rst_hold",   32'(bus.pipe_hold), 32'd0);
        chk("rst_req",    32'(bus.trap_req), 32'd0);
        chk("rst_cause",  32'(bus.trap_cause), 32'd0);
        chk("rst_vector", 32'(bus.trap_vector), 32'd0);
        chk("rst_count",  32'(bus.trap_count), 32'd0);
        chk("rst_err",    32'(bus.trap_err), 32'd0);

        $display("txn tagtrap with pov_unflow");
        bus.valid = 1'b1; bus.tagtrap = 1'b1; bus.pov_unflow = 1'b1;
        step();
        clear_in();
        bump_count();
        chk("tag_squash_n1", 32'(bus.squash), 32'd1);
        chk("tag_hold_n1",   32'(bus.pipe_hold), 32'd1);
        chk("tag_req_n1",    32'(bus.trap_req), 32'd0);
        chk("tag_cause",     32'(bus.trap_cause), 32'd1);
        chk("tag_vector",    32'(bus.trap_vector), 32'h88);
        chk("tag_count",     32'(bus.trap_count), 32'(exp_count));
        step();
        chk("tag_squash_n2", 32'(bus.squash), 32'd0);
        chk("tag_req_n2",    32'(bus.trap_req), 32'd1);
        step();
        step();
        chk("tag_req_n4",    32'(bus.trap_req), 32'd1);
        bus.handler_ack = 1'b1;
        step();
        bus.handler_ack = 1'b0;
        chk("tag_req_m1",    32'(bus.trap_req), 32'd0);
        chk("tag_hold_m1",   32'(bus.pipe_hold), 32'd1);
        step();
        chk("tag_hold_m2",   32'(bus.pipe_hold), 32'd1);
        step();
        chk("tag_hold_m3",   32'(bus.pipe_hold), 32'd0);
        chk("tag_cause_kept", 32'(bus.trap_cause), 32'd1);

        $display("txn ack outside REQ");
        bus.handler_ack = 1'b1;
        step();
        bus.handler_ack = 1'b0;
        chk("ack_idle_hold", 32'(bus.pipe_hold), 32'd0);

        $display("txn trapinstr num=5");
        bus.valid = 1'b1; bus.trapinstr = 1'b1; bus.trap_num = 3'b101;
        step();
        clear_in();
        bump_count();
        chk("ti_cause",  32'(bus.trap_cause), 32'd4);
        chk("ti_vector", 32'(bus.trap_vector), 32'hA5);
        finish_trap("ti");

        $display("txn skip pulses");
        bus.valid = 1'b1; bus.skip_cond_enable = 1'b1; bus.cond_true = 1'b1;
        step();
        chk("skip1_pulse",  32'(bus.skip_next), 32'd1);
        chk("skip1_squash", 32'(bus.squash), 32'd0);
        chk("skip1_hold",   32'(bus.pipe_hold), 32'd0);
        step();
        chk("skip2_pulse",  32'(bus.skip_next), 32'd1);
        clear_in();
        step();
        chk("skip_end",     32'(bus.skip_next), 32'd0);
        chk("skip_count",   32'(bus.trap_count), 32'(exp_count));
        bus.valid = 1'b1; bus.skip_cond_enable = 1'b1; bus.cond_true = 1'b0;
        step();
        clear_in();
        chk("skip_false",   32'(bus.skip_next), 32'd0);

        $display("txn gstrap with skip");
        bus.valid = 1'b1; bus.gstrap = 1'b1; bus.skip_cond_enable = 1'b1; bus.cond_true = 1'b1;
        step();
        clear_in();
        bump_count();
        chk("gs_skip",   32'(bus.skip_next), 32'd0);
        chk("gs_cause",  32'(bus.trap_cause), 32'd3);
        chk("gs_vector", 32'(bus.trap_vector), 32'h98);
        chk("gs_squash", 32'(bus.squash), 32'd1);
        finish_trap("gs");

        $display("txn stalled tagtrap");
        bus.valid = 1'b1; bus.tagtrap = 1'b1; bus.stall_in = 1'b1;
        step();
        clear_in();
        chk("stall_squash", 32'(bus.squash), 32'd0);
        chk("stall_hold",   32'(bus.pipe_hold), 32'd0);
        chk("stall_count",  32'(bus.trap_count), 32'(exp_count));

        $display("txn trapinstr during REQ");
        bus.valid = 1'b1; bus.pov_unflow = 1'b1;
        step();
        clear_in();
        bump_count();
        chk("busy_cause0", 32'(bus.trap_cause), 32'd2);
        chk("busy_vector", 32'(bus.trap_vector), 32'h90);
        step();
        bus.valid = 1'b1; bus.trapinstr = 1'b1; bus.trap_num = 3'd7;
        step();
        step();
        clear_in();
        chk("busy_cause",  32'(bus.trap_cause), 32'd2);
        chk("busy_count",  32'(bus.trap_count), 32'(exp_count));
        finish_trap("busy");

        $display("txn timeout");
        bus.valid = 1'b1; bus.tagtrap = 1'b1;
        step();
        clear_in();
        bump_count();
        step();
        n = 0;
        while (bus.trap_req && n < 200) begin
            chk("tmo_err_low", 32'(bus.trap_err), 32'd0);
            step();
            n++;
        end
        chk("tmo_req_cycles", 32'(n), 32'd64);
        chk("tmo_err_set",    32'(bus.trap_err), 32'd1);
        chk("tmo_drain_hold", 32'(bus.pipe_hold), 32'd1);
        step();
        step();
        chk("tmo_released",   32'(bus.pipe_hold), 32'd0);
        step();
        chk("tmo_err_sticky", 32'(bus.trap_err), 32'd1);

        $display("txn reset during REQ");
        bus.valid = 1'b1; bus.trapinstr = 1'b1; bus.trap_num = 3'd2;
        step();
        clear_in();
        step();
        chk("rreq_req_pre", 32'(bus.trap_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_count = 0;
        chk("rreq_req",    32'(bus.trap_req), 32'd0);
        chk("rreq_hold",   32'(bus.pipe_hold), 32'd0);
        chk("rreq_cause",  32'(bus.trap_cause), 32'd0);
        chk("rreq_vector", 32'(bus.trap_vector), 32'd0);
        chk("rreq_count",  32'(bus.trap_count), 32'd0);
        chk("rreq_err",    32'(bus.trap_err), 32'd0);
        bus.valid = 1'b1; bus.tagtrap = 1'b1;
        step();
        clear_in();
        chk("rreq_idle_again", 32'(bus.squash), 32'd1);
        bump_count();
        finish_trap("rreq");

        $display("txn saturation");
        for (int i = 1; i < 260; i++) begin
            bus.valid = 1'b1; bus.tagtrap = 1'b1;
            step();
            clear_in();
            bump_count();
            step();
            bus.handler_ack = 1'b1;
            step();
            bus.handler_ack = 1'b0;
            step();
            step();
            if (i == 254 || i == 259)
                chk($sformatf("sat_count_%0d", i + 1), 32'(bus.trap_count), 32'(exp_count));
        end
        chk("sat_final", 32'(bus.trap_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
